// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit_if : redirect, instruction-memory and decode-side handshakes
// Revision: 1.0
// ============================================================================
interface instr_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_instr, id_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    input  imem_req, imem_addr, id_valid, id_instr, id_pc
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit : one-outstanding imem fetcher feeding a PC-tagged FIFO
// Revision: 1.0
// ============================================================================
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset_n,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned     c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]   c_depth   = (c_aw + 1)'(DEPTH);
  localparam logic [c_aw:0]   c_cnt_one = (c_aw + 1)'(1);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_mem_instr [DEPTH];
  logic [31:0]     r_mem_pc    [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic [c_aw:0]   w_count_nxt;
  logic            w_id_valid;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_push_pc;

  assign w_id_valid = (r_count != '0);
  // A redirect kills both the same-cycle pop and any same-cycle push.
  assign w_push     = (r_state == S_WAIT) && bus.imem_rvalid && !bus.redirect_valid;
  assign w_pop      = w_id_valid && bus.id_ready && !bus.redirect_valid;
  // fetch_pc already advanced on grant, so the outstanding request sits one word behind.
  assign w_push_pc  = r_fetch_pc - 32'd4;

  always_comb begin
    w_count_nxt = r_count;
    if (bus.redirect_valid) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + c_cnt_one;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - c_cnt_one;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.redirect_valid || (r_count < c_depth)) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (bus.imem_gnt) w_state_nxt = bus.redirect_valid ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          w_state_nxt = (w_count_nxt < c_depth) ? S_REQ : S_IDLE;
        end else if (bus.redirect_valid) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (bus.imem_rvalid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_instr <= '{default: '0};
      r_mem_pc    <= '{default: '0};
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;

      if (bus.redirect_valid) begin
        r_fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
      end else if ((r_state == S_REQ) && bus.imem_gnt) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end

      if (bus.redirect_valid) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_mem_instr[r_wr_ptr] <= bus.imem_rdata;
          r_mem_pc[r_wr_ptr]    <= w_push_pc;
          r_wr_ptr              <= r_wr_ptr + c_ptr_one;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
      end
    end
  end

  assign bus.imem_req  = (r_state == S_REQ);
  assign bus.imem_addr = r_fetch_pc;
  assign bus.id_valid  = w_id_valid;
  assign bus.id_instr  = r_mem_instr[r_rd_ptr];
  assign bus.id_pc     = r_mem_pc[r_rd_ptr];

  // Requests are only issued with room left, so a push can never find the FIFO full.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    w_push |-> (r_count < c_depth));

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage that sits directly upstream of the single-cycle core's decode/execute logic and replaces the combinational imem lookup with a handshaked fetch.
- Issues word requests to an instruction memory with variable latency, one outstanding at a time.
- Buffers returned instructions, with their PCs, in a small FIFO.
- Presents them to the core on a valid/ready interface.
- Branch/jump redirects from the core flush the buffer and discard any in-flight response.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  reset; one clock, synchronous, active-low
redirect_valid  input  1  core requests PC change this cycle (taken branch/jump)
redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 0
imem_req  output  1  fetch request valid
imem_addr  output  32  word-aligned fetch address; held stable while imem_req=1 and imem_gnt=0
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid (one per granted request, >= 1 cycle after grant)
imem_rdata  input  32  instruction word
id_valid  output  1  FIFO head holds a valid instruction
id_ready  input  1  core consumes head this cycle
id_instr  output  32  head instruction
id_pc  output  32  head PC

Behaviour:
- Reset (reset_n=0 at edge) sets:
  - state=IDLE, fetch_pc=RESET_PC.
  - FIFO count=0; rd/wr pointers=0; all FIFO storage=0.
- Outputs during and just after reset: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0.
- Reset mid-operation aborts any outstanding request. The imem shares this reset, so no stale response arrives.
- FSM states:
  - IDLE: imem_req=0. Go to REQ when count<DEPTH.
  - REQ: imem_req=1, imem_addr=fetch_pc. On imem_gnt: fetch_pc<=fetch_pc+4 (32-bit wrap), go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid: push {fetch_pc_of_request, imem_rdata}, then go to REQ if post-push count<DEPTH, else IDLE.
  - DROP: imem_req=0. On imem_rvalid: discard the data, go to REQ.
- Request issue only from REQ/IDLE with no outstanding request. A push is therefore always into a non-full FIFO; an overflow condition is impossible and an assertion must check it.
- imem_rvalid in IDLE or REQ is ignored.
- FIFO behaviour:
  - id_valid = (count!=0); id_instr/id_pc driven from registered head entry, zero logic latency.
  - Pop when id_valid && id_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Redirect (redirect_valid=1) has highest priority:
  - Flushes the FIFO: count<=0, pointers<=0; id_valid=0 the next cycle. A same-cycle pop and any same-cycle push are discarded.
  - fetch_pc<=redirect_pc&~3.
  - Next state by current state:
    - REQ without gnt: -> REQ; new address presented next cycle.
    - REQ with gnt: -> DROP.
    - WAIT without rvalid: -> DROP.
    - WAIT with rvalid: -> REQ (response discarded).
    - DROP without rvalid: -> DROP.
    - DROP with rvalid: -> REQ.
    - IDLE: -> REQ.
- Latency with zero-wait memory (gnt same cycle as req, rvalid next cycle):
  - Reset released before cycle 0.
  - imem_req=1 in cycle 1; rvalid in cycle 2; id_valid=1 in cycle 3.
  - Steady-state throughput: one instruction per 2 cycles.
  - Redirect to first new-target id_valid: 3 cycles.
- id_pc of every delivered instruction equals the address used for its request.
- Instructions are delivered in order with no duplicates and no gaps, except at redirects.

Test Plan:
- Reset then zero-wait memory returning addr as data, id_ready=1 -> imem_req first in cycle 1 at 0x0; id_valid first in cycle 3 with id_pc=0x0, id_instr=0x0; subsequent id_pc 0x4, 0x8, 0xC in order.
- id_ready=0, DEPTH=4 -> exactly 4 grants (0x0..0xC); imem_req stays 0 afterwards. Assert id_ready for 1 cycle -> head 0x0 pops and exactly one new request to 0x10 follows.
- Gnt delayed 3 cycles -> imem_addr holds 0x8 and imem_req stays 1 through the stall; no extra request.
- Redirect to 0x100 while in WAIT (rvalid 2 cycles later, data 0xDEAD) -> 0xDEAD never appears on id_instr; next request addr 0x100; first delivered id_pc=0x100.
- Redirect 0x203 with simultaneous rvalid and FIFO holding 2 entries plus a pop -> next cycle id_valid=0; next request addr 0x200.
- Drive reset_n=0 for 1 cycle mid-fetch with FIFO non-empty -> id_valid=0 and imem_req=0 the next cycle; fetch restarts at RESET_PC.
